// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer.
package stream_demux_pkg;

    // Packet framing state: IDLE waits for a first beat, ROUTE follows an open packet.
    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_e;

    // Width of the optional packet/drop statistics counters.
    localparam int CNT_W = 16;

    // Largest supported channel count.
    localparam int MAX_N = 8;

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel: a single-entry register with valid/ready handshake.
// space_o tells the router whether a new beat can be written this cycle
// (register empty, or being drained by the downstream at the same edge).
module stream_demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fill_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic             space_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // Load on fill, otherwise clear valid once the downstream takes the beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (fill_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; payload only changes when a new beat is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign space_o = !valid_q || ready_i;

endmodule

// File: rtl/stream_demux.sv
// Packet-level stream demultiplexer: the channel is chosen by sel on the
// first beat of a packet and held until the last beat. Packets aimed at a
// channel index >= N are swallowed without stalling the source.
// Optional statistics counters are enabled with STREAM_DEMUX_STATS_EN.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [SELW-1:0]  sel,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]     out_valid,
    output logic [N-1:0]     out_last,
    input  logic [N-1:0]     out_ready,
`ifdef STREAM_DEMUX_STATS_EN
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
`endif
    output logic             busy
);

    state_e          state_q, state_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic [SELW-1:0] target;
    logic            target_ok;
    logic            target_space;
    logic            accept;
    logic [N-1:0]    fill;
    logic [N-1:0]    space;

    // Destination of the current beat: live sel on a first beat, latched sel afterwards.
    always_comb begin
        target       = (state_q == ROUTE) ? cur_sel_q : sel;
        target_ok    = int'(target) < N;
        target_space = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (int'(target) == k) begin
                target_space = space[k];
            end
        end
    end

    // Discarded packets never stall; ready is forced low while reset is held.
    assign in_ready = rst_n && (!target_ok || target_space);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == ROUTE);

    // Packet framing: open on a non-final first beat, close on an accepted last beat.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_sel_d = sel;
                    if (!in_last) begin
                        state_d = ROUTE;
                    end
                end
            end
            ROUTE: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Framing state and latched destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        assign fill[gi] = accept && target_ok && (int'(target) == gi);

        stream_demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .fill_i  (fill[gi]),
            .data_i  (in_data),
            .last_i  (in_last),
            .ready_i (out_ready[gi]),
            .valid_o (out_valid[gi]),
            .data_o  (out_data[gi*WIDTH +: WIDTH]),
            .last_o  (out_last[gi]),
            .space_o (space[gi])
        );
    end

`ifdef STREAM_DEMUX_STATS_EN
    logic [CNT_W-1:0] pkt_q;
    logic [CNT_W-1:0] drop_q;

    // Count completed packets per outcome, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            drop_q <= '0;
        end else if (accept && in_last) begin
            if (target_ok) begin
                if (pkt_q != '1) pkt_q <= pkt_q + CNT_W'(1);
            end else begin
                if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    assign pkt_cnt  = pkt_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an N=4 and an N=3 instance share one stimulus
// stream; a queue-based reference model checks both on every cycle, and a
// directed sequence pins the model with hand-computed expectations.
// Statistics ports are checked when STREAM_DEMUX_STATS_EN is defined.
module tb_stream_demux;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] in_data;
    logic         in_valid, in_last;
    logic [1:0]   sel;
    logic [3:0]   out_ready;

    logic         in_ready4, busy4;
    logic [31:0]  out_data4;
    logic [3:0]   out_valid4, out_last4;
    logic         in_ready3, busy3;
    logic [23:0]  out_data3;
    logic [2:0]   out_valid3, out_last3;
`ifdef STREAM_DEMUX_STATS_EN
    logic [15:0]  pkt4, drop4, pkt3, drop3;
`endif

    stream_demux #(.WIDTH(W), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready4), .sel(sel),
        .out_data(out_data4), .out_valid(out_valid4), .out_last(out_last4),
        .out_ready(out_ready),
`ifdef STREAM_DEMUX_STATS_EN
        .pkt_cnt(pkt4), .drop_cnt(drop4),
`endif
        .busy(busy4)
    );

    stream_demux #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready3), .sel(sel),
        .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3),
        .out_ready(out_ready[2:0]),
`ifdef STREAM_DEMUX_STATS_EN
        .pkt_cnt(pkt3), .drop_cnt(drop3),
`endif
        .busy(busy3)
    );

    // Uniform views of both instances for the per-cycle comparison.
    logic [63:0] od [2];
    logic [7:0]  ov [2];
    logic [7:0]  ol [2];
    logic        ir [2];
    logic        bz [2];
    assign od[0] = 64'(out_data4);
    assign od[1] = 64'(out_data3);
    assign ov[0] = 8'(out_valid4);
    assign ov[1] = 8'(out_valid3);
    assign ol[0] = 8'(out_last4);
    assign ol[1] = 8'(out_last3);
    assign ir[0] = in_ready4;
    assign ir[1] = in_ready3;
    assign bz[0] = busy4;
    assign bz[1] = busy3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-channel queues of beats awaiting delivery,
    // plus packet-open flag and latched destination per instance.
    int       nch [2] = '{4, 3};
    bit [8:0] chq [2][8][$];
    bit       open_m [2];
    int       cur_m [2];
    int       pkt_m [2];
    int       drop_m [2];

    // Compare both instances against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                chk($sformatf("d%0d reset in_ready", i), 64'(ir[i]), 64'd0);
                chk($sformatf("d%0d reset out_valid", i), 64'(ov[i]), 64'd0);
                chk($sformatf("d%0d reset out_last", i), 64'(ol[i]), 64'd0);
                chk($sformatf("d%0d reset out_data", i), od[i], 64'd0);
                chk($sformatf("d%0d reset busy", i), 64'(bz[i]), 64'd0);
                for (int k = 0; k < 8; k++) chq[i][k].delete();
                open_m[i] = 0;
                cur_m[i]  = 0;
                pkt_m[i]  = 0;
                drop_m[i] = 0;
            end else begin
                logic [7:0] ev;
                int  tgt;
                bit  ok, er, acc;
                ev = '0;
                for (int k = 0; k < nch[i]; k++) begin
                    if (chq[i][k].size() > 0) begin
                        ev[k] = 1'b1;
                        chk($sformatf("d%0d ch%0d data", i, k), 64'(od[i][k*8 +: 8]), 64'(chq[i][k][0][7:0]));
                        chk($sformatf("d%0d ch%0d last", i, k), 64'(ol[i][k]), 64'(chq[i][k][0][8]));
                    end
                end
                chk($sformatf("d%0d out_valid", i), 64'(ov[i]), 64'(ev));
                tgt = open_m[i] ? cur_m[i] : int'(sel);
                ok  = tgt < nch[i];
                er  = !ok || chq[i][tgt].size() == 0 || out_ready[tgt];
                chk($sformatf("d%0d in_ready", i), 64'(ir[i]), 64'(er));
                chk($sformatf("d%0d busy", i), 64'(bz[i]), 64'(open_m[i]));
`ifdef STREAM_DEMUX_STATS_EN
                chk($sformatf("d%0d pkt_cnt", i), (i == 0) ? 64'(pkt4) : 64'(pkt3), 64'(pkt_m[i]));
                chk($sformatf("d%0d drop_cnt", i), (i == 0) ? 64'(drop4) : 64'(drop3), 64'(drop_m[i]));
`endif
                for (int k = 0; k < nch[i]; k++) begin
                    if (chq[i][k].size() > 0 && out_ready[k]) void'(chq[i][k].pop_front());
                end
                acc = in_valid && er;
                if (acc) begin
                    if (ok) chq[i][tgt].push_back({in_last, in_data});
                    if (!open_m[i]) begin
                        cur_m[i] = int'(sel);
                        if (!in_last) open_m[i] = 1;
                    end else if (in_last) begin
                        open_m[i] = 0;
                    end
                    if (in_last) begin
                        if (ok) pkt_m[i] = (pkt_m[i] < 65535) ? pkt_m[i] + 1 : 65535;
                        else    drop_m[i] = (drop_m[i] < 65535) ? drop_m[i] + 1 : 65535;
                    end
                end
            end
        end
    end

    // Present one beat and hold it until the N=4 instance accepts it.
    // Returns at 1 time unit after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] s, input logic l,
                             output int waits, output logic r3);
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        sel      = s;
        in_last  = l;
        waits    = 0;
        r3       = 1'b0;
        forever begin
            @(negedge clk);
            acc = in_ready4;
            r3  = in_ready3;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL send_beat timeout: data %02h never accepted", d);
                break;
            end
        end
        $display("beat data=%02h sel=%0d last=%0b waits=%0d", d, s, l, waits);
    endtask

    initial begin
        int   w;
        logic r3;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        sel       = '0;
        out_ready = 4'hF;

        // Reset held, then released between edges.
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready during reset", 64'(in_ready4), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("in_ready after release", 64'(in_ready4), 64'd1);
        @(posedge clk);
        #1;

        // Single-beat packet to channel 2.
        send_beat(8'hA5, 2'd2, 1'b1, w, r3);
        in_valid = 1'b0;
        chk("1beat out_valid", 64'(out_valid4), 64'h4);
        chk("1beat data ch2", 64'(out_data4[23:16]), 64'hA5);
        chk("1beat last ch2", 64'(out_last4[2]), 64'd1);
        chk("1beat busy", 64'(busy4), 64'd0);
        @(posedge clk);
        #1;

        // Four-beat packet to channel 1; sel moves to 3 mid-packet and must be ignored.
        for (int b = 0; b < 4; b++) begin
            send_beat(8'h10 + 8'(b), (b == 0) ? 2'd1 : 2'd3, (b == 3), w, r3);
            chk("4beat data ch1", 64'(out_data4[15:8]), 64'h10 + 64'(b));
            chk("4beat ch3 idle", 64'(out_valid4[3]), 64'd0);
            chk("4beat busy", 64'(busy4), (b == 3) ? 64'd0 : 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Stalled channel 0 must not block channel 2.
        out_ready = 4'b1110;
        send_beat(8'h10, 2'd0, 1'b1, w, r3);
        in_valid = 1'b0;
        sel      = 2'd0;
        #1;
        chk("stall in_ready ch0", 64'(in_ready4), 64'd0);
        send_beat(8'h22, 2'd2, 1'b1, w, r3);
        in_valid = 1'b0;
        chk("stall other waits", 64'(w), 64'd0);
        chk("stall ch2 data", 64'(out_data4[23:16]), 64'h22);
        chk("stall ch0 held", 64'(out_data4[7:0]), 64'h10);
        @(posedge clk);
        #1;
        chk("stall ch0 still valid", 64'(out_valid4[0]), 64'd1);
        out_ready = 4'hF;
        @(posedge clk);
        #1;
        chk("stall ch0 drained", 64'(out_valid4[0]), 64'd0);

        // Back-to-back two-beat packets at full rate.
        for (int j = 0; j < 8; j++) begin
            send_beat(8'h40 + 8'(j), 2'((j / 2) % 3), (j % 2 == 1), w, r3);
            chk("b2b waits", 64'(w), 64'd0);
            chk("b2b out_valid", 64'(out_valid4), 64'(1 << ((j / 2) % 3)));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // sel=3: routed on the N=4 instance, discarded on the N=3 instance.
        for (int b = 0; b < 3; b++) begin
            send_beat(8'h60 + 8'(b), 2'd3, (b == 2), w, r3);
            chk("discard in_ready3", 64'(r3), 64'd1);
            chk("discard out_valid3", 64'(out_valid3), 64'd0);
        end
        in_valid = 1'b0;
`ifdef STREAM_DEMUX_STATS_EN
        chk("discard drop_cnt", 64'(drop3), 64'd1);
        chk("discard pkt_cnt", 64'(pkt3), 64'd8);
`endif
        @(posedge clk);
        #1;

        // Reset in the middle of a packet drops it.
        for (int b = 0; b < 3; b++) send_beat(8'h30 + 8'(b), 2'd1, 1'b0, w, r3);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid4), 64'd0);
        chk("midrst busy", 64'(busy4), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(8'h77, 2'd0, 1'b1, w, r3);
        in_valid = 1'b0;
        chk("post-rst out_valid", 64'(out_valid4), 64'h1);
        chk("post-rst data ch0", 64'(out_data4[7:0]), 64'h77);

        // Randomised traffic with random backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            sel       = 2'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
